hazard_stall_ctrl: RTL and testbench

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

---
 rtl/hazard_stall_ctrl.sv | 150 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use and branch stalls, E/D-stage bypass selects,
// and a multi-cycle multiply/divide unit sequencer that freezes F/D/E while it runs.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       memtoregE,
  input  logic       memtoregM,
  input  logic       branchD,
  input  logic       pcsrcD,
  input  logic       jumpD,
  input  logic       mdu_startE,
  input  logic       mdu_divE,
  output logic       enF,
  output logic       enD,
  output logic       enE,
  output logic       enM,
  output logic       clrD,
  output logic       clrE,
  output logic       clrM,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic       mdu_busy,
  output logic       hilo_we
);

  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  mdu_state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       mdu_stall;
  logic       lw_stall;
  logic       br_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The start cycle itself stalls, so BUSY only has to cover the remaining N-1 cycles.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mdu_stall = 1'b0;
    mdu_busy  = 1'b0;
    hilo_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mdu_startE) begin
          state_d   = BUSY;
          cnt_d     = mdu_divE ? DIV_LOAD : MULT_LOAD;
          mdu_stall = reset;
        end
      end
      BUSY: begin
        mdu_stall = 1'b1;
        mdu_busy  = 1'b1;
        if (cnt_q == 6'd1) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      DONE: begin
        mdu_busy = 1'b1;
        hilo_we  = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    lw_stall = memtoregE && regwriteE && ((rtE == rsD) || (rtE == rtD)) && (rtE != 5'd0);
    br_stall = branchD &&
               ((regwriteE && (writeregE != 5'd0) &&
                 ((writeregE == rsD) || (writeregE == rtD))) ||
                (memtoregM && (writeregM != 5'd0) &&
                 ((writeregM == rsD) || (writeregM == rtD))));
  end

  // A redirect never clears D while anything is stalled: the stalled D instruction must survive.
  always_comb begin
    enF  = 1'b1;
    enD  = 1'b1;
    enE  = 1'b1;
    enM  = 1'b1;
    clrD = 1'b0;
    clrE = 1'b0;
    clrM = 1'b0;
    if (mdu_stall) begin
      enF  = 1'b0;
      enD  = 1'b0;
      enE  = 1'b0;
      clrM = 1'b1;
    end else if (lw_stall || br_stall) begin
      enF  = 1'b0;
      enD  = 1'b0;
      clrE = 1'b1;
    end else begin
      clrD = pcsrcD || jumpD;
    end
  end

  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (regwriteM && (writeregM == rsE) && (rsE != 5'd0)) begin
      forwardAE = 2'b10;
    end else if (regwriteW && (writeregW == rsE) && (rsE != 5'd0)) begin
      forwardAE = 2'b01;
    end
    if (regwriteM && (writeregM == rtE) && (rtE != 5'd0)) begin
      forwardBE = 2'b10;
    end else if (regwriteW && (writeregW == rtE) && (rtE != 5'd0)) begin
      forwardBE = 2'b01;
    end
    forwardAD = regwriteM && (writeregM == rsD) && (rsD != 5'd0);
    forwardBD = regwriteM && (writeregM == rtD) && (rtD != 5'd0);
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus randomized traffic, all checked
// against an elapsed-cycle model of the MDU and the stall/forward rules.
module tb_hazard_stall_ctrl;
  localparam int MULT_N = 4;
  localparam int DIV_N  = 33;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic       branchD, pcsrcD, jumpD, mdu_startE, mdu_divE;
  logic       enF, enD, enE, enM, clrD, clrE, clrM;
  logic [1:0] forwardAE, forwardBE;
  logic       forwardAD, forwardBD, mdu_busy, hilo_we;

  int checks   = 0;
  int failures = 0;
  int k        = -1;   // cycles elapsed since the current MDU op started, -1 when none
  int op_n     = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .pcsrcD(pcsrcD), .jumpD(jumpD),
    .mdu_startE(mdu_startE), .mdu_divE(mdu_divE),
    .enF(enF), .enD(enD), .enE(enE), .enM(enM),
    .clrD(clrD), .clrE(clrE), .clrM(clrM),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .mdu_busy(mdu_busy), .hilo_we(hilo_we)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
    {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM} = '0;
    {branchD, pcsrcD, jumpD, mdu_startE, mdu_divE} = '0;
  endtask

  function automatic logic [1:0] fwd_e(input logic [4:0] r);
    if (r == 0) return 2'b00;
    if (regwriteM && writeregM == r) return 2'b10;
    if (regwriteW && writeregW == r) return 2'b01;
    return 2'b00;
  endfunction

  // Compare every output against the model for the current cycle.
  task automatic settle_and_check();
    logic       stall, busy, hilo, lw, br;
    logic [3:0] en;
    logic [2:0] clr;
    #3;
    stall = reset && ((k < 0) ? mdu_startE : (k < op_n));
    busy  = reset && (k > 0);
    hilo  = reset && (k > 0) && (k == op_n);
    lw = memtoregE && regwriteE && rtE != 0 && (rtE == rsD || rtE == rtD);
    br = branchD && ((regwriteE && writeregE != 0 && (writeregE == rsD || writeregE == rtD)) ||
                     (memtoregM && writeregM != 0 && (writeregM == rsD || writeregM == rtD)));
    if (stall) begin
      en = 4'b0001; clr = 3'b001;
    end else if (lw || br) begin
      en = 4'b0011; clr = 3'b010;
    end else begin
      en = 4'b1111; clr = {pcsrcD | jumpD, 2'b00};
    end
    chk("en",    {28'd0, enF, enD, enE, enM}, {28'd0, en});
    chk("clr",   {29'd0, clrD, clrE, clrM}, {29'd0, clr});
    chk("fwdE",  {28'd0, forwardAE, forwardBE}, {28'd0, fwd_e(rsE), fwd_e(rtE)});
    chk("fwdD",  {30'd0, forwardAD, forwardBD},
                 {30'd0, regwriteM && rsD != 0 && writeregM == rsD,
                         regwriteM && rtD != 0 && writeregM == rtD});
    chk("busy",  {31'd0, mdu_busy}, {31'd0, busy});
    chk("hilo",  {31'd0, hilo_we}, {31'd0, hilo});
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) k = -1;
    else if (k < 0) begin
      if (mdu_startE) begin
        op_n = mdu_divE ? DIV_N : MULT_N;
        k = 1;
      end
    end else if (k < op_n) k++;
    else k = -1;
    #1;
  endtask

  task automatic run_op(input logic div, input int exp_n, input string tag);
    int  stalls;
    bit  got_hilo;
    stalls = 0;
    got_hilo = 0;
    mdu_startE = 1'b1;
    mdu_divE = div;
    for (int i = 0; i < 100 && !got_hilo; i++) begin
      settle_and_check();
      if (!enE) stalls++;
      if (hilo_we) begin
        got_hilo = 1;
        chk({tag, "_en_at_done"}, {31'd0, enE}, 32'd1);
        mdu_startE = 1'b0;
      end
      tick();
    end
    chk({tag, "_stalls"}, stalls, exp_n);
    chk({tag, "_hilo_seen"}, {31'd0, got_hilo}, 32'd1);
    settle_and_check();
    tick();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    mdu_startE = 1'b1;
    #2;
    chk("rst_busy", {31'd0, mdu_busy}, 32'd0);
    chk("rst_enE", {31'd0, enE}, 32'd1);
    mdu_startE = 1'b0;
    @(posedge clk); #1;
    settle_and_check();
    tick();
    reset = 1'b1;
    settle_and_check();
    tick();

    run_op(1'b0, MULT_N, "mult");
    run_op(1'b1, DIV_N, "div");

    memtoregE = 1; regwriteE = 1; rtE = 5; rsD = 5;
    settle_and_check();
    chk("lw_en", {28'd0, enF, enD, enE, enM}, 32'h3);
    chk("lw_clrE", {31'd0, clrE}, 32'd1);
    tick();
    rtE = 0; rsD = 0;
    settle_and_check();
    chk("lw_r0_en", {28'd0, enF, enD, enE, enM}, 32'hF);
    tick();
    clear_inputs();

    regwriteM = 1; regwriteW = 1; writeregM = 7; writeregW = 7; rsE = 7;
    settle_and_check();
    chk("fwd_prio", {30'd0, forwardAE}, 32'd2);
    tick();
    writeregM = 3;
    settle_and_check();
    chk("fwd_w", {30'd0, forwardAE}, 32'd1);
    tick();
    rsE = 0; writeregM = 0; writeregW = 0;
    settle_and_check();
    chk("fwd_r0", {30'd0, forwardAE}, 32'd0);
    tick();
    clear_inputs();

    memtoregE = 1; regwriteE = 1; rtE = 9; rtD = 9; pcsrcD = 1;
    settle_and_check();
    chk("sf_clrD", {31'd0, clrD}, 32'd0);
    chk("sf_clrE", {31'd0, clrE}, 32'd1);
    tick();
    memtoregE = 0;
    settle_and_check();
    chk("flush_clrD", {31'd0, clrD}, 32'd1);
    tick();
    clear_inputs();

    mdu_startE = 1; mdu_divE = 1;
    settle_and_check();
    tick();
    settle_and_check();
    tick();
    reset = 1'b0;
    settle_and_check();
    chk("abort_busy", {31'd0, mdu_busy}, 32'd0);
    chk("abort_stall", {31'd0, enE}, 32'd1);
    mdu_startE = 0;
    for (int i = 0; i < 3; i++) begin
      settle_and_check();
      chk("abort_hilo", {31'd0, hilo_we}, 32'd0);
      tick();
    end
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      settle_and_check();
      chk("post_abort_hilo", {31'd0, hilo_we}, 32'd0);
      tick();
    end
    run_op(1'b0, MULT_N, "mult2");

    for (int i = 0; i < 1500; i++) begin
      {rsD, rtD, rsE, rtE} = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      {writeregE, writeregM, writeregW} = {5'($urandom_range(0, 3)),
                                           5'($urandom_range(0, 3)),
                                           5'($urandom_range(0, 3))};
      {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM} = 5'($urandom);
      {branchD, pcsrcD, jumpD, mdu_divE} = 4'($urandom);
      mdu_startE = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 59) != 0);
      settle_and_check();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
